// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Two-port writeback arbiter feeding a single register-file write
//            port, with a busy scoreboard for RAW hazard detection.
//            Optional macro WB_RR_ARB_EN selects round-robin arbitration
//            (default: fixed priority, port 0 over port 1).
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb0_valid,
  output logic            wb0_ready,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_valid,
  output logic            wb1_ready,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            reg_we,
  output logic [AW-1:0]   writeaddr,
  output logic [XLEN-1:0] writedata
);

  localparam logic [AW-1:0] c_zero_addr = '0;

  logic            r_buf0_full;
  logic [AW-1:0]   r_buf0_addr;
  logic [XLEN-1:0] r_buf0_data;
  logic            r_buf1_full;
  logic [AW-1:0]   r_buf1_addr;
  logic [XLEN-1:0] r_buf1_data;

  logic            w_prio1;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_grant_any;
  logic            w_xfer0;
  logic            w_xfer1;
  logic            w_cap0;
  logic            w_cap1;
  logic [NREG-1:0] w_busy;

  // w_prio1 high means port 1 wins a contested cycle.
  assign w_grant0    = r_buf0_full && (!r_buf1_full || !w_prio1);
  assign w_grant1    = r_buf1_full && (!r_buf0_full ||  w_prio1);
  assign w_grant_any = w_grant0 || w_grant1;

  assign wb0_ready = !r_buf0_full || w_grant0;
  assign wb1_ready = !r_buf1_full || w_grant1;

  assign w_xfer0 = wb0_valid && wb0_ready;
  assign w_xfer1 = wb1_valid && wb1_ready;
  assign w_cap0  = w_xfer0 && (wb0_addr != c_zero_addr);
  assign w_cap1  = w_xfer1 && (wb1_addr != c_zero_addr);

`ifdef WB_RR_ARB_EN
  logic r_prio_ptr;

  assign w_prio1 = r_prio_ptr;

  // After a contested grant the loser takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio_ptr <= 1'b0;
    end else if (r_buf0_full && r_buf1_full) begin
      r_prio_ptr <= w_grant0;
    end
  end
`else
  assign w_prio1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf0_full <= 1'b0;
      r_buf0_addr <= '0;
      r_buf0_data <= '0;
    end else if (w_cap0) begin
      r_buf0_full <= 1'b1;
      r_buf0_addr <= wb0_addr;
      r_buf0_data <= wb0_data;
    end else if (w_grant0) begin
      r_buf0_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf1_full <= 1'b0;
      r_buf1_addr <= '0;
      r_buf1_data <= '0;
    end else if (w_cap1) begin
      r_buf1_full <= 1'b1;
      r_buf1_addr <= wb1_addr;
      r_buf1_data <= wb1_data;
    end else if (w_grant1) begin
      r_buf1_full <= 1'b0;
    end
  end

  // Address/data hold their last value on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_we    <= 1'b0;
      writeaddr <= '0;
      writedata <= '0;
    end else if (w_grant_any) begin
      reg_we    <= 1'b1;
      writeaddr <= w_grant1 ? r_buf1_addr : r_buf0_addr;
      writedata <= w_grant1 ? r_buf1_data : r_buf0_data;
    end else begin
      reg_we    <= 1'b0;
    end
  end

  assign w_busy[0] = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    logic r_busy_bit;

    // A new writer issuing on the clearing edge keeps the register busy.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_busy_bit <= 1'b0;
      end else if (issue_valid && (issue_rd == AW'(gi))) begin
        r_busy_bit <= 1'b1;
      end else if (reg_we && (writeaddr == AW'(gi))) begin
        r_busy_bit <= 1'b0;
      end
    end

    assign w_busy[gi] = r_busy_bit;
  end

  assign rs1_busy = w_busy[rs1_addr];
  assign rs2_busy = w_busy[rs2_addr];

endmodule
`default_nettype wire
